// File: rtl/cge_csr_pkg.sv
// Shared types for CSR bus masters.
// Bridge FSM states and default bus geometry.
package cge_csr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2,
    ACK     = 2'd3
  } csr_state_e;

  localparam int CSR_A_WIDTH     = 10;
  localparam int CSR_D_WIDTH     = 16;
  localparam int CSR_BE_WIDTH    = 2;
  localparam int CSR_RD_LATENCY  = 2;
  localparam int CSR_CNT_WIDTH   = 3;
  localparam int CSR_MAX_LATENCY = 7;

  function automatic bit csr_lat_ok(int lat);
    return (lat >= 1) && (lat <= CSR_MAX_LATENCY);
  endfunction

endpackage

// File: rtl/amm_csr_bridge.sv
// Avalon-MM slave to CSR bus master bridge.
// One command in flight; fixed-latency CSR reads.
module amm_csr_bridge
  import cge_csr_pkg::*;
#(
  parameter int A_WIDTH    = CSR_A_WIDTH,
  parameter int D_WIDTH    = CSR_D_WIDTH,
  parameter int BE_WIDTH   = CSR_BE_WIDTH,
  parameter int RD_LATENCY = CSR_RD_LATENCY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [A_WIDTH-1:0]  amm_address,
  input  logic                amm_read,
  input  logic                amm_write,
  input  logic [D_WIDTH-1:0]  amm_writedata,
  input  logic [BE_WIDTH-1:0] amm_byteenable,
  output logic [D_WIDTH-1:0]  amm_readdata,
  output logic                amm_waitrequest,
  output logic [A_WIDTH-1:0]  csr_addr,
  output logic [BE_WIDTH-1:0] csr_be,
  output logic [D_WIDTH-1:0]  csr_wr_data,
  output logic                csr_wr_en,
  input  logic [D_WIDTH-1:0]  csr_rd_data
);

  if (!csr_lat_ok(RD_LATENCY)) begin : g_bad_lat
    $error("amm_csr_bridge: RD_LATENCY must be 1..7");
  end

  if (BE_WIDTH * 8 != D_WIDTH) begin : g_bad_be
    $error("amm_csr_bridge: BE_WIDTH must be D_WIDTH/8");
  end

  localparam logic [CSR_CNT_WIDTH-1:0] LAT_LD =
    CSR_CNT_WIDTH'(RD_LATENCY);

  csr_state_e state_q;
  csr_state_e state_d;

  logic [CSR_CNT_WIDTH-1:0] cnt_q;

  logic accept_wr;
  logic accept_rd;
  logic rd_last;

  assign accept_wr = (state_q == IDLE) && amm_write;
  assign accept_rd = (state_q == IDLE) && amm_read
                   && !amm_write;
  // Last wait cycle: slave data is valid now.
  assign rd_last = (state_q == RD_WAIT)
                 && (cnt_q <= CSR_CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_wr) begin
          state_d = WRITE;
        end else if (accept_rd) begin
          state_d = RD_WAIT;
        end
      end
      WRITE: begin
        state_d = ACK;
      end
      RD_WAIT: begin
        if (rd_last) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept_rd) begin
      cnt_q <= LAT_LD;
    end else if ((state_q == RD_WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CSR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_addr <= '0;
      csr_be   <= '0;
    end else if (accept_wr || accept_rd) begin
      csr_addr <= amm_address;
      csr_be   <= amm_byteenable;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_wr_data <= '0;
    end else if (accept_wr) begin
      csr_wr_data <= amm_writedata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amm_readdata <= '0;
    end else if (rd_last) begin
      amm_readdata <= csr_rd_data;
    end
  end

  assign csr_wr_en       = (state_q == WRITE);
  assign amm_waitrequest = (state_q != ACK);

endmodule

// File: tb/tb_amm_csr_bridge.sv
// Bench for amm_csr_bridge: three builds (latency 2, 1, 7)
// with delayed-slave models and a queued ack scoreboard.
module tb_amm_csr_bridge;

  localparam int N = 3;

  logic        clk;
  logic        rst_n;
  logic [9:0]  amm_address     [N];
  logic        amm_read        [N];
  logic        amm_write       [N];
  logic [15:0] amm_writedata   [N];
  logic [1:0]  amm_byteenable  [N];
  logic [15:0] amm_readdata    [N];
  logic        amm_waitrequest [N];
  logic [9:0]  csr_addr        [N];
  logic [1:0]  csr_be          [N];
  logic [15:0] csr_wr_data     [N];
  logic        csr_wr_en       [N];
  logic [15:0] csr_rd_data     [N];

  typedef struct {
    int          g;
    int          ack_cyc;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] rmem [N][1024];
  logic [15:0] exp_rd [N];
  int          idle_from [N];
  int          we_cyc [N];
  logic [9:0]  we_addr [N];
  logic [15:0] we_data [N];
  logic [1:0]  we_be [N];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 7);
  endfunction

  function automatic logic [15:0] seed(int g, int a);
    return 16'((a * 37) ^ (g << 12) ^ 16'h5A5A);
  endfunction

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

    logic [15:0] smem [1024];

    amm_csr_bridge #(
      .A_WIDTH    (10),
      .D_WIDTH    (16),
      .BE_WIDTH   (2),
      .RD_LATENCY (LAT)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .amm_address     (amm_address[g]),
      .amm_read        (amm_read[g]),
      .amm_write       (amm_write[g]),
      .amm_writedata   (amm_writedata[g]),
      .amm_byteenable  (amm_byteenable[g]),
      .amm_readdata    (amm_readdata[g]),
      .amm_waitrequest (amm_waitrequest[g]),
      .csr_addr        (csr_addr[g]),
      .csr_be          (csr_be[g]),
      .csr_wr_data     (csr_wr_data[g]),
      .csr_wr_en       (csr_wr_en[g]),
      .csr_rd_data     (csr_rd_data[g])
    );

    initial begin
      for (int a = 0; a < 1024; a++) smem[a] = seed(g, a);
      if (g == 0) smem[1023] = 16'h1234;
    end

    always @(posedge clk) begin
      if (csr_wr_en[g]) begin
        for (int b = 0; b < 2; b++) begin
          if (csr_be[g][b])
            smem[csr_addr[g]][8*b +: 8] <= csr_wr_data[g][8*b +: 8];
        end
      end
    end

    // Slave data becomes valid LAT cycles into the read.
    if (LAT == 1) begin : g_comb
      assign csr_rd_data[g] = smem[csr_addr[g]];
    end else begin : g_pipe
      logic [15:0] dl [8];
      always @(posedge clk) begin
        dl[0] <= smem[csr_addr[g]];
        for (int i = 1; i < 8; i++) dl[i] <= dl[i-1];
      end
      assign csr_rd_data[g] = dl[LAT-2];
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
        if (!amm_waitrequest[g]) begin
          if (sb.size() == 0) begin
            chk($sformatf("ack_unexp_%0d", g), 32'(sb.size()), 1);
          end else begin
            e = sb.pop_front();
            chk($sformatf("ack_inst_%0d", g), g, e.g);
            chk($sformatf("ack_cyc_%0d", g), cyc, e.ack_cyc);
            chk($sformatf("rdata_%0d", g), amm_readdata[g], e.rdata);
          end
        end
        if (csr_wr_en[g]) begin
          chk($sformatf("we_cyc_%0d", g), cyc, we_cyc[g]);
          chk($sformatf("we_addr_%0d", g), csr_addr[g], we_addr[g]);
          chk($sformatf("we_data_%0d", g), csr_wr_data[g], we_data[g]);
          chk($sformatf("we_be_%0d", g), csr_be[g], we_be[g]);
          we_cyc[g] = -1;
        end
      end
    end
  end

  // Called mid-cycle; returns mid-cycle in the ack cycle.
  task automatic cmd(int g, bit wr, bit rd, logic [9:0] a,
                     logic [15:0] d, logic [1:0] be);
    int   p;
    exp_t e;
    bit   got;
    p = (idle_from[g] > cyc) ? idle_from[g] : cyc;
    amm_address[g]    = a;
    amm_writedata[g]  = d;
    amm_byteenable[g] = be;
    amm_write[g]      = wr;
    amm_read[g]       = rd;
    e.g = g;
    if (wr) begin
      e.ack_cyc  = p + 2;
      e.rdata    = exp_rd[g];
      we_cyc[g]  = p + 1;
      we_addr[g] = a;
      we_data[g] = d;
      we_be[g]   = be;
      for (int b = 0; b < 2; b++) begin
        if (be[b]) rmem[g][a][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      e.ack_cyc = p + lat_of(g) + 1;
      e.rdata   = rmem[g][a];
      exp_rd[g] = e.rdata;
    end
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      #1;
      got = !amm_waitrequest[g];
    end
    chk($sformatf("ack_seen_%0d", g), 32'(got), 1);
    amm_write[g] = 1'b0;
    amm_read[g]  = 1'b0;
    idle_from[g] = cyc + 1;
  endtask

  task automatic gap(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_rst_outputs(string tag);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("%s_wait_%0d", tag, g), amm_waitrequest[g], 1);
      chk($sformatf("%s_we_%0d", tag, g), csr_wr_en[g], 0);
      chk($sformatf("%s_addr_%0d", tag, g), csr_addr[g], 0);
      chk($sformatf("%s_be_%0d", tag, g), csr_be[g], 0);
      chk($sformatf("%s_wd_%0d", tag, g), csr_wr_data[g], 0);
      chk($sformatf("%s_rd_%0d", tag, g), amm_readdata[g], 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      amm_address[g]    = '0;
      amm_read[g]       = 1'b0;
      amm_write[g]      = 1'b0;
      amm_writedata[g]  = '0;
      amm_byteenable[g] = '0;
      exp_rd[g]         = '0;
      idle_from[g]      = 0;
      we_cyc[g]         = -1;
      for (int a = 0; a < 1024; a++) rmem[g][a] = seed(g, a);
    end
    rmem[0][1023] = 16'h1234;

    gap(3);
    chk_rst_outputs("rst");
    rst_n = 1'b1;

    cmd(0, 1, 0, 10'h015, 16'hBEEF, 2'b11);
    gap(2);
    cmd(0, 0, 1, 10'h3FF, 16'h0000, 2'b11);
    gap(1);
    cmd(0, 0, 1, 10'h015, 16'h0000, 2'b11);
    gap(2);
    cmd(0, 1, 1, 10'h007, 16'hA5C3, 2'b11);
    cmd(0, 1, 0, 10'h007, 16'h5A01, 2'b01);
    cmd(0, 0, 1, 10'h007, 16'h0000, 2'b11);
    cmd(0, 0, 1, 10'h3FF, 16'h0000, 2'b10);
    cmd(0, 1, 0, 10'h020, 16'h00FF, 2'b10);
    cmd(0, 0, 1, 10'h020, 16'h0000, 2'b11);
    chk("addr_hold", csr_addr[0], 10'h020);

    gap(2);
    amm_address[0] = 10'h02A;
    amm_read[0]    = 1'b1;
    gap(1);
    rst_n       = 1'b0;
    amm_read[0] = 1'b0;
    #1;
    chk_rst_outputs("mid");
    gap(2);
    chk_rst_outputs("mid2");
    rst_n = 1'b1;
    for (int g = 0; g < N; g++) begin
      exp_rd[g]    = '0;
      idle_from[g] = cyc;
      we_cyc[g]    = -1;
    end
    gap(6);
    chk("post_rst_wait", amm_waitrequest[0], 1);
    cmd(0, 1, 0, 10'h030, 16'h4321, 2'b11);
    cmd(0, 0, 1, 10'h3FF, 16'h0000, 2'b11);

    gap(1);
    cmd(1, 0, 1, 10'h100, 16'h0000, 2'b11);
    cmd(1, 0, 1, 10'h101, 16'h0000, 2'b11);
    cmd(1, 1, 0, 10'h101, 16'hC0DE, 2'b11);
    cmd(1, 0, 1, 10'h101, 16'h0000, 2'b11);
    gap(1);
    cmd(2, 0, 1, 10'h200, 16'h0000, 2'b11);
    cmd(2, 0, 1, 10'h201, 16'h0000, 2'b11);
    cmd(2, 1, 0, 10'h200, 16'h9ABC, 2'b10);
    cmd(2, 0, 1, 10'h200, 16'h0000, 2'b11);

    gap(4);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amm_csr_bridge.md
AMM_CSR_BRIDGE -- requirements
Module: amm_csr_bridge

Interface
REQ-001 The module SHALL have these parameters:
- A_WIDTH, default 10, address width.
- D_WIDTH, default 16, data width.
- BE_WIDTH, default 2, byte-enable width (D_WIDTH/8).
- RD_LATENCY, default 2, CSR read latency in cycles, legal range 1..7.

REQ-002 The module SHALL have these ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock for both sides.
- rst_n  in  1  asynchronous active-low reset.
- amm_address  in  A_WIDTH  Avalon-MM word address.
- amm_read  in  1  read request.
- amm_write  in  1  write request.
- amm_writedata  in  D_WIDTH  write data.
- amm_byteenable  in  BE_WIDTH  byte enables.
- amm_readdata  out  D_WIDTH  read data, valid when amm_waitrequest=0 on a read.
- amm_waitrequest  out  1  stall; 0 for exactly one cycle per completed command.
- csr_addr  out  A_WIDTH  CSR address, master side of the team CSR bus.
- csr_be  out  BE_WIDTH  CSR byte enables.
- csr_wr_data  out  D_WIDTH  CSR write data.
- csr_wr_en  out  1  single-cycle CSR write strobe.
- csr_rd_data  in  D_WIDTH  CSR read data, valid RD_LATENCY cycles after csr_addr is stable.

Function
REQ-003 The module SHALL use the states IDLE, WRITE, RD_WAIT and ACK.
REQ-004 amm_waitrequest SHALL equal 1 in every state except ACK, where it SHALL be 0.
REQ-005 In IDLE with amm_write=1 at edge T0, the module SHALL latch address, writedata and byteenable, then enter WRITE.
REQ-006 In WRITE (cycle T1), the module SHALL drive csr_wr_en=1 for exactly that cycle, then enter ACK.
REQ-007 A write SHALL therefore complete with amm_waitrequest=0 in T2 and return to IDLE in T3.
REQ-008 In IDLE with amm_read=1 (and amm_write=0) at T0, the module SHALL latch address and byteenable, load the latency counter with RD_LATENCY, and enter RD_WAIT.
REQ-009 RD_WAIT SHALL last RD_LATENCY cycles (T1..T0+RD_LATENCY).
REQ-010 csr_rd_data SHALL be registered into amm_readdata on the edge ending cycle T0+RD_LATENCY, followed by ACK in cycle T0+RD_LATENCY+1.
REQ-011 If amm_read and amm_write are both 1 in IDLE, the module SHALL perform the write only; the read SHALL be ignored.
REQ-012 csr_addr, csr_be and csr_wr_data SHALL be driven from the latch registers only, and SHALL hold their values from T1 until the next accepted command.
REQ-013 csr_wr_en SHALL never be 1 outside WRITE.
REQ-014 amm_readdata SHALL hold its last captured value until the next read capture; writes SHALL NOT alter it.
REQ-015 ACK SHALL always return to IDLE; back-to-back commands SHALL therefore be accepted no earlier than the cycle after ACK.
REQ-016 Commands presented while not in IDLE SHALL be ignored until IDLE; the master holds them under waitrequest per the Avalon protocol.
REQ-017 The latency counter SHALL be 3 bits wide and decrement to 0 without wrap; RD_LATENCY outside 1..7 SHALL be rejected by an elaboration-time check.

Reset
REQ-018 While rst_n=0, the module SHALL hold state=IDLE and amm_waitrequest=1.
REQ-019 While rst_n=0, the module SHALL hold csr_wr_en=0.
REQ-020 While rst_n=0, the module SHALL hold csr_addr, csr_be, csr_wr_data, amm_readdata and the counter at 0.
REQ-021 Reset asserted mid-command (any of WRITE, RD_WAIT, ACK) SHALL abort the command immediately: no csr_wr_en pulse and no ACK after release.
REQ-022 The first command SHALL be sampled on the first rising edge after rst_n deasserts.

Structure
REQ-023 The state enum and the default width constants SHALL live in a shared package, cge_csr_pkg, for reuse by other CSR masters.
REQ-024 The module SHALL be a single module with no sub-module; the FSM, latches and counter SHALL be inline.

Verification
REQ-025 Write with addr=0x15, data=0xBEEF, be=2'b11 -> csr_wr_en high exactly in T1 with csr_addr=0x15 and csr_wr_data=0xBEEF; waitrequest=0 only in T2.
REQ-026 Read with addr=0x3FF, RD_LATENCY=2, and a slave model returning 0x1234 two cycles after address -> amm_readdata=0x1234 with waitrequest=0 in T3; csr_wr_en never asserts.
REQ-027 Read and write asserted together, addr=0x7 -> one write pulse, no read capture, amm_readdata unchanged.
REQ-028 Back-to-back write then read to 0x7 -> the read returns the written value, and the second command is accepted in the cycle after the first ACK.
REQ-029 rst_n pulsed low during RD_WAIT -> waitrequest=1, no ACK, state IDLE after release, and a subsequent read completes normally.
REQ-030 RD_LATENCY=1 and RD_LATENCY=7 builds -> ACK in T2 and T8 respectively, and captured data matches the slave model.
